// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel/line counters with sync, blanking and line/frame start pulses
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk_25MHz,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] H_Counter_Value,
  output logic [CNT_W-1:0] V_Counter_Value,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic lw_q, lw_d, fw_q, fw_d, ls_q, fs_q;
  always_comb begin
    lw_d = pix_en && (h_q == H_LAST);
    fw_d = lw_d && (v_q == V_LAST);
    h_d  = pix_en ? (lw_d ? '0 : h_q + CNT_W'(1)) : h_q;
    v_d  = lw_d ? (fw_d ? '0 : v_q + CNT_W'(1)) : v_q;
  end
  // pulses trail the wrap by one clock so they appear while the counters read (0,x)+1
  always_ff @(posedge clk_25MHz) begin
    if (!reset_n) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      lw_q <= 1'b0;
      fw_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      lw_q <= lw_d;
      fw_q <= fw_d;
      ls_q <= lw_q;
      fs_q <= fw_q;
    end
  end
  assign H_Counter_Value = h_q;
  assign V_Counter_Value = v_q;
  assign video_on        = (h_q < H_VIS) && (v_q < V_VIS);
  assign hsync           = (h_q >= HS_BEG && h_q <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync           = (v_q >= VS_BEG && v_q <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
  assign line_start      = ls_q;
  assign frame_start     = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for default and small-parameter timing generators
module tb_vga_timing_gen;
  localparam int HA[2] = '{640, 4};
  localparam int HF[2] = '{16, 1};
  localparam int HS[2] = '{96, 2};
  localparam int HB[2] = '{48, 1};
  localparam int VA[2] = '{480, 3};
  localparam int VF[2] = '{10, 1};
  localparam int VS[2] = '{2, 1};
  localparam int VB[2] = '{33, 1};
  localparam bit HP[2] = '{1'b0, 1'b1};
  localparam bit VP[2] = '{1'b0, 1'b1};
  logic clk = 1'b0, reset_n = 1'b0, pix_en = 1'b0;
  logic [15:0] h0, v0, h1, v1;
  logic hs0, vs0, vid0, ls0, fs0, hs1, vs1, vid1, ls1, fs1;
  int total = 0, bad = 0;
  int mh[2], mv[2];
  logic mlw[2], mfw[2], mls[2], mfs[2];
  logic [36:0] q0[$], q1[$];
  always #5 clk = ~clk;
  vga_timing_gen dut0 (
    .clk_25MHz(clk), .reset_n(reset_n), .pix_en(pix_en),
    .H_Counter_Value(h0), .V_Counter_Value(v0), .hsync(hs0), .vsync(vs0),
    .video_on(vid0), .line_start(ls0), .frame_start(fs0)
  );
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(16)
  ) dut1 (
    .clk_25MHz(clk), .reset_n(reset_n), .pix_en(pix_en),
    .H_Counter_Value(h1), .V_Counter_Value(v1), .hsync(hs1), .vsync(vs1),
    .video_on(vid1), .line_start(ls1), .frame_start(fs1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [36:0] expv(input int k);
    logic hs_in, vs_in;
    hs_in = mh[k] >= HA[k] + HF[k] && mh[k] < HA[k] + HF[k] + HS[k];
    vs_in = mv[k] >= VA[k] + VF[k] && mv[k] < VA[k] + VF[k] + VS[k];
    return {16'(mh[k]), 16'(mv[k]), hs_in ? HP[k] : !HP[k], vs_in ? VP[k] : !VP[k],
            mh[k] < HA[k] && mv[k] < VA[k], mls[k], mfs[k]};
  endfunction
  task automatic step(input logic r, input logic e);
    int ht, vt;
    logic hw, fw;
    reset_n = r;
    pix_en  = e;
    for (int k = 0; k < 2; k++) begin
      ht = HA[k] + HF[k] + HS[k] + HB[k];
      vt = VA[k] + VF[k] + VS[k] + VB[k];
      if (!r) begin
        mh[k] = ht - 1; mv[k] = vt - 1;
        mlw[k] = 0; mfw[k] = 0; mls[k] = 0; mfs[k] = 0;
      end else begin
        hw = e && mh[k] == ht - 1;
        fw = hw && mv[k] == vt - 1;
        mls[k] = mlw[k]; mfs[k] = mfw[k];
        mlw[k] = hw; mfw[k] = fw;
        if (e) mh[k] = hw ? 0 : mh[k] + 1;
        if (hw) mv[k] = fw ? 0 : mv[k] + 1;
      end
    end
    q0.push_back(expv(0));
    q1.push_back(expv(1));
    @(posedge clk);
    #1;
    chk("dut0", {h0, v0, hs0, vs0, vid0, ls0, fs0}, q0.pop_front());
    chk("dut1", {h1, v1, hs1, vs1, vid1, ls1, fs1}, q1.pop_front());
  endtask
  initial begin
    int hl, vd0, vd1, hh1, vh1, lc, fc, last, prev, n;
    step(0, 1); step(0, 1); step(0, 0);
    chk("rst_h0", h0, 799); chk("rst_v0", v0, 524); chk("rst_vid0", vid0, 0);
    chk("rst_hs0", hs0, 1); chk("rst_vs0", vs0, 1); chk("rst_ls0", ls0, 0); chk("rst_fs0", fs0, 0);
    chk("rst_h1", h1, 7); chk("rst_v1", v1, 5); chk("rst_hs1", hs1, 0); chk("rst_vs1", vs1, 0);
    repeat (10) step(1, 0);
    chk("hold_h0", h0, 799); chk("hold_v0", v0, 524); chk("hold_ls0", ls0, 0); chk("hold_fs0", fs0, 0);
    hl = 0; vd0 = 0; vd1 = 0; hh1 = 0; vh1 = 0; lc = 0; fc = 0; last = -1;
    for (int i = 0; i < 1600; i++) begin
      step(1, 1);
      if (i == 0) begin chk("first_h0", h0, 0); chk("first_v0", v0, 0); chk("first_ls0", ls0, 0); end
      if (i == 1) begin chk("start_ls0", ls0, 1); chk("start_fs0", fs0, 1); end
      if (i == 2) begin chk("end_ls0", ls0, 0); chk("end_fs0", fs0, 0); end
      if (!hs0) hl++;
      if (vid0) vd0++;
      if (i < 96 && vid1) vd1++;
      if (i < 96 && hs1) hh1++;
      if (i < 96 && vs1) vh1++;
      if (ls0) lc++;
      if (fs1) begin
        fc++;
        if (last >= 0) chk("fs1_gap", i - last, 48);
        last = i;
      end
    end
    chk("hs0_low", hl, 192); chk("vid0_cnt", vd0, 1280); chk("vid1_cnt", vd1, 24);
    chk("hs1_hi", hh1, 24); chk("vs1_hi", vh1, 16); chk("ls0_cnt", lc, 2); chk("fs1_cnt", fc, 34);
    last = -1; prev = 0; n = 0;
    for (int i = 0; i < 3400; i++) begin
      step(1, i % 2 == 0);
      if (ls0) begin
        n++;
        chk("ls0_wide", prev, 0);
        if (last >= 0) chk("ls0_gap", i - last, 1600);
        last = i;
      end
      prev = ls0;
    end
    chk("ls0_pulses", n, 3);
    n = 0;
    while (mh[0] != 300 && n < 2000) begin step(1, 1); n++; end
    chk("mid_h0", h0, 300);
    step(0, 1);
    chk("mrst_h0", h0, 799); chk("mrst_v0", v0, 524); chk("mrst_ls0", ls0, 0); chk("mrst_fs0", fs0, 0);
    repeat (3) step(1, 0);
    step(1, 1);
    chk("rel_h0", h0, 0); chk("rel_v0", v0, 0);
    step(0, 1);
    chk("nopart_ls0", ls0, 0); chk("nopart_fs0", fs0, 0);
    step(1, 1);
    chk("rel2_h0", h0, 0);
    step(1, 1);
    chk("rel2_ls0", ls0, 1); chk("rel2_fs0", fs0, 1);
    step(1, 1);
    chk("rel2_ls0_off", ls0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
